// File: rtl/register_bank_arbiter.sv
// register_bank_arbiter: per-bank round-robin read arbitration for a banked
// vector register file. Operand read ports compete for banks selected by the
// low register-index bits; each bank grants at most one port per cycle, and a
// one-stage grant pipeline routes the bank read data back to the winner.
module register_bank_arbiter #(
    parameter int unsigned NumRequesters = 8,
    parameter int unsigned NumBanks      = 4,
    parameter int unsigned NumWarps      = 8,
    parameter int unsigned RegIdxWidth   = 6,
    parameter int unsigned RegWidth      = 32,
    parameter int unsigned WarpWidth     = 32,
    localparam int unsigned WidWidth      = (NumWarps > 1) ? $clog2(NumWarps) : 1,
    localparam int unsigned BankSelWidth  = $clog2(NumBanks),
    localparam int unsigned BankAddrWidth = WidWidth + RegIdxWidth - BankSelWidth,
    localparam int unsigned DataWidth     = RegWidth * WarpWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumRequesters-1:0]            req_valid_i,
    input  logic [NumRequesters*WidWidth-1:0]   req_wid_i,
    input  logic [NumRequesters*RegIdxWidth-1:0] req_reg_idx_i,
    output logic [NumRequesters-1:0]            req_ready_o,
    output logic [NumRequesters-1:0]            rsp_valid_o,
    output logic [NumRequesters*DataWidth-1:0]  rsp_data_o,
    input  logic [NumBanks-1:0]                 bank_busy_i,
    output logic [NumBanks-1:0]                 bank_req_valid_o,
    output logic [NumBanks*BankAddrWidth-1:0]   bank_req_addr_o,
    input  logic [NumBanks*DataWidth-1:0]       bank_rsp_data_i
);

    localparam int unsigned ReqSelWidth = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

    logic [WidWidth-1:0]    req_wid     [NumRequesters];
    logic [RegIdxWidth-1:0] req_idx     [NumRequesters];

    logic [NumBanks-1:0]    win_valid;
    logic [ReqSelWidth-1:0] win_idx     [NumBanks];
    logic [ReqSelWidth-1:0] rr_ptr_q    [NumBanks];
    logic [ReqSelWidth-1:0] rr_ptr_d    [NumBanks];

    logic [NumBanks-1:0]    gnt_valid_q;
    logic [ReqSelWidth-1:0] gnt_idx_q   [NumBanks];

    // Unpack the flattened per-requester request fields.
    always_comb begin
        for (int unsigned r = 0; r < NumRequesters; r++) begin
            req_wid[r] = req_wid_i[r*WidWidth +: WidWidth];
            req_idx[r] = req_reg_idx_i[r*RegIdxWidth +: RegIdxWidth];
        end
    end

    // Per-bank round-robin search starting at rr_ptr, wrapping over all requesters.
    always_comb begin
        int unsigned            pos;
        logic [ReqSelWidth-1:0] cand;
        pos       = 0;
        cand      = '0;
        win_valid = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            win_idx[b] = '0;
            for (int unsigned k = 0; k < NumRequesters; k++) begin
                pos = 32'(rr_ptr_q[b]) + k;
                if (pos >= NumRequesters) begin
                    pos = pos - NumRequesters;
                end
                cand = ReqSelWidth'(pos);
                if (!win_valid[b] && !rst_i && !bank_busy_i[b] && req_valid_i[cand]
                    && (req_idx[cand][BankSelWidth-1:0] == BankSelWidth'(b))) begin
                    win_valid[b] = 1'b1;
                    win_idx[b]   = cand;
                end
            end
        end
    end

    // Grant-cycle outputs: ready to the winner, bank read request, pointer advance.
    always_comb begin
        req_ready_o      = '0;
        bank_req_valid_o = '0;
        bank_req_addr_o  = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            rr_ptr_d[b] = rr_ptr_q[b];
            if (win_valid[b]) begin
                req_ready_o[win_idx[b]] = 1'b1;
                bank_req_valid_o[b]     = 1'b1;
                bank_req_addr_o[b*BankAddrWidth +: BankAddrWidth] =
                    {req_wid[win_idx[b]], req_idx[win_idx[b]][RegIdxWidth-1:BankSelWidth]};
                rr_ptr_d[b] = (32'(win_idx[b]) == NumRequesters - 1) ? '0
                                                                      : win_idx[b] + ReqSelWidth'(1);
            end
        end
    end

    // Round-robin pointers and the one-deep grant pipeline; reset drops in-flight grants.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_valid_q <= '0;
            for (int unsigned b = 0; b < NumBanks; b++) begin
                rr_ptr_q[b]  <= '0;
                gnt_idx_q[b] <= '0;
            end
        end else begin
            gnt_valid_q <= win_valid;
            for (int unsigned b = 0; b < NumBanks; b++) begin
                rr_ptr_q[b]  <= rr_ptr_d[b];
                gnt_idx_q[b] <= win_idx[b];
            end
        end
    end

    // Route each bank's read data to the requester granted in the previous cycle.
    always_comb begin
        rsp_valid_o = '0;
        rsp_data_o  = '0;
        for (int unsigned r = 0; r < NumRequesters; r++) begin
            for (int unsigned b = 0; b < NumBanks; b++) begin
                if (gnt_valid_q[b] && (gnt_idx_q[b] == ReqSelWidth'(r))) begin
                    rsp_valid_o[r] = 1'b1;
                    rsp_data_o[r*DataWidth +: DataWidth] = bank_rsp_data_i[b*DataWidth +: DataWidth];
                end
            end
        end
    end

endmodule

// File: tb/tb_register_bank_arbiter.sv
// Bench for register_bank_arbiter: directed scenarios followed by random
// traffic, all checked against a distance-based round-robin reference model.
module tb_register_bank_arbiter;

    localparam int N    = 8;
    localparam int NB   = 4;
    localparam int NW   = 8;
    localparam int RIW  = 6;
    localparam int RW   = 16;
    localparam int WW   = 2;
    localparam int WIDW = 3;
    localparam int BAW  = WIDW + RIW - 2;
    localparam int DW   = RW * WW;
    localparam int ROWS = (1 << RIW) / NB;
    localparam int CW   = 256;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [N-1:0]        req_valid_i;
    logic [N*WIDW-1:0]   req_wid_i;
    logic [N*RIW-1:0]    req_reg_idx_i;
    logic [N-1:0]        req_ready_o;
    logic [N-1:0]        rsp_valid_o;
    logic [N*DW-1:0]     rsp_data_o;
    logic [NB-1:0]       bank_busy_i;
    logic [NB-1:0]       bank_req_valid_o;
    logic [NB*BAW-1:0]   bank_req_addr_o;
    logic [NB*DW-1:0]    bank_rsp_data_i;

    register_bank_arbiter #(
        .NumRequesters(N),
        .NumBanks     (NB),
        .NumWarps     (NW),
        .RegIdxWidth  (RIW),
        .RegWidth     (RW),
        .WarpWidth    (WW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_wid_i       (req_wid_i),
        .req_reg_idx_i   (req_reg_idx_i),
        .req_ready_o     (req_ready_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_data_o      (rsp_data_o),
        .bank_busy_i     (bank_busy_i),
        .bank_req_valid_o(bank_req_valid_o),
        .bank_req_addr_o (bank_req_addr_o),
        .bank_rsp_data_i (bank_rsp_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Stimulus state
    logic [N-1:0]    v;
    logic [NB-1:0]   busy;
    logic [WIDW-1:0] wid   [N];
    logic [RIW-1:0]  idx   [N];
    logic [DW-1:0]   bdata [NB];

    // Reference model state
    int           ptr [NB];
    logic [N-1:0] prev_gnt;
    int           prev_bank [N];
    int           gnt_of_bank [NB];
    int           waitc [N];
    int           checks = 0;
    int           errors = 0;

    always_comb begin
        req_valid_i = v;
        bank_busy_i = busy;
        for (int r = 0; r < N; r++) begin
            req_wid_i[r*WIDW +: WIDW]    = wid[r];
            req_reg_idx_i[r*RIW +: RIW]  = idx[r];
        end
        for (int b = 0; b < NB; b++) begin
            bank_rsp_data_i[b*DW +: DW] = bdata[b];
        end
    end

    function automatic int bank_of(input int r);
        return int'(idx[r]) % NB;
    endfunction

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int b = 0; b < NB; b++) ptr[b] = 0;
        prev_gnt = '0;
        for (int r = 0; r < N; r++) waitc[r] = 0;
    endtask

    // Sample at the falling edge and compare every output with the model.
    task automatic eval();
        logic [N-1:0]    exp_ready;
        logic [NB-1:0]   exp_bvalid;
        logic [NB*BAW-1:0] exp_addr;
        logic [N*DW-1:0] exp_data;
        int best, bestd, d;
        logic other;
        @(negedge clk_i);
        exp_ready  = '0;
        exp_bvalid = '0;
        exp_addr   = '0;
        exp_data   = '0;
        for (int b = 0; b < NB; b++) begin
            gnt_of_bank[b] = -1;
            if (!rst_i && !busy[b]) begin
                best  = -1;
                bestd = N;
                for (int r = 0; r < N; r++) begin
                    if (v[r] && bank_of(r) == b) begin
                        d = (r - ptr[b] + N) % N;
                        if (d < bestd) begin
                            bestd = d;
                            best  = r;
                        end
                    end
                end
                if (best >= 0) begin
                    gnt_of_bank[b]   = best;
                    exp_ready[best]  = 1'b1;
                    exp_bvalid[b]    = 1'b1;
                    exp_addr[b*BAW +: BAW] = BAW'(int'(wid[best]) * ROWS + int'(idx[best]) / NB);
                end
            end
        end
        for (int r = 0; r < N; r++) begin
            if (prev_gnt[r]) exp_data[r*DW +: DW] = bdata[prev_bank[r]];
        end
        chk("req_ready", req_ready_o, exp_ready);
        chk("bank_req_valid", bank_req_valid_o, exp_bvalid);
        chk("bank_req_addr", bank_req_addr_o, exp_addr);
        chk("rsp_valid", rsp_valid_o, prev_gnt);
        chk("rsp_data", rsp_data_o, exp_data);
        // Starvation: count grants of a bank to others while a requester waits on it.
        for (int r = 0; r < N; r++) begin
            if (!v[r] || rst_i || req_ready_o[r]) begin
                waitc[r] = 0;
            end else if (!busy[bank_of(r)]) begin
                other = 1'b0;
                for (int q = 0; q < N; q++) begin
                    if (q != r && v[q] && req_ready_o[q] && bank_of(q) == bank_of(r)) other = 1'b1;
                end
                if (other) begin
                    waitc[r]++;
                    chk("starve_bound", CW'(waitc[r] <= N - 1), CW'(1));
                end
            end
        end
    endtask

    // Advance one clock and update the model with this cycle's grants.
    task automatic adv();
        @(posedge clk_i);
        prev_gnt = '0;
        if (!rst_i) begin
            for (int b = 0; b < NB; b++) begin
                if (gnt_of_bank[b] >= 0) begin
                    ptr[b] = (gnt_of_bank[b] + 1) % N;
                    prev_gnt[gnt_of_bank[b]]  = 1'b1;
                    prev_bank[gnt_of_bank[b]] = b;
                end
            end
        end
        #1;
    endtask

    initial begin
        int ord [6];
        ord = '{0, 1, 3, 0, 1, 3};

        // Reset with all requesters asserting valid: nothing may be granted.
        rst_i = 1'b1;
        v     = '1;
        busy  = '0;
        for (int r = 0; r < N; r++) begin
            wid[r] = WIDW'(r);
            idx[r] = RIW'(r);
        end
        for (int b = 0; b < NB; b++) bdata[b] = DW'($urandom);
        reset_model();
        for (int b = 0; b < NB; b++) gnt_of_bank[b] = -1;
        #1;
        eval();
        chk("reset_ready", req_ready_o, '0);
        chk("reset_rsp_data", rsp_data_o, '0);
        adv();
        eval();
        adv();
        rst_i = 1'b0;
        v     = '0;

        // Single request: r=2, wid=1, reg_idx=6 -> bank 2, row {1,1}.
        v[2] = 1'b1; wid[2] = 3'd1; idx[2] = 6'd6;
        eval();
        chk("single_ready", req_ready_o, 8'h04);
        chk("single_bank_valid", bank_req_valid_o, 4'h4);
        chk("single_addr", bank_req_addr_o[2*BAW +: BAW], 7'd17);
        adv();
        v[2] = 1'b0;
        bdata[2] = 32'hCAFE_0002;
        eval();
        chk("single_rsp_valid", rsp_valid_o, 8'h04);
        chk("single_rsp_data", rsp_data_o[2*DW +: DW], 32'hCAFE_0002);
        adv();

        // Requesters 0,1,3 hammer bank 0: strict rotation 0,1,3,...
        v = 8'b0000_1011;
        idx[0] = 6'd0; idx[1] = 6'd4; idx[3] = 6'd8;
        for (int i = 0; i < 6; i++) begin
            bdata[0] = DW'($urandom);
            eval();
            chk("rr_order", req_ready_o, 8'(1 << ord[i]));
            adv();
        end

        // Grant to requester 1, then reset while its read is in flight.
        v = 8'b0000_0010;
        eval();
        chk("pre_reset_ready", req_ready_o, 8'h02);
        adv();
        rst_i = 1'b1;
        v = '0;
        reset_model();
        eval();
        chk("midrst_rsp_valid", rsp_valid_o, '0);
        chk("midrst_bank_valid", bank_req_valid_o, '0);
        adv();
        rst_i = 1'b0;
        v = 8'b0000_1001;
        idx[0] = 6'd0; idx[3] = 6'd12;
        eval();
        chk("postrst_ptr_zero", req_ready_o, 8'h01);
        chk("postrst_no_rsp", rsp_valid_o, '0);
        adv();
        v = '0;

        // Four requesters on four banks in the same cycle.
        v = 8'hF0;
        idx[4] = 6'd0; idx[5] = 6'd1; idx[6] = 6'd2; idx[7] = 6'd3;
        eval();
        chk("parallel_ready", req_ready_o, 8'hF0);
        chk("parallel_bank_valid", bank_req_valid_o, 4'hF);
        adv();
        v = '0;
        for (int b = 0; b < NB; b++) bdata[b] = DW'($urandom);
        eval();
        chk("parallel_rsp_valid", rsp_valid_o, 8'hF0);
        adv();

        // Bank 1 busy for three cycles with requester 5 pending.
        v = 8'h20;
        idx[5] = 6'd5;
        busy = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("busy_no_grant", req_ready_o, '0);
            adv();
        end
        busy = '0;
        eval();
        chk("busy_release_grant", req_ready_o, 8'h20);
        adv();
        v = '0;

        // Random traffic; requesters hold valid until granted.
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int r = 0; r < N; r++) begin
                if (v[r] && prev_gnt[r]) v[r] = 1'b0;
                if (!v[r] && $urandom_range(99) < 45) begin
                    v[r]   = 1'b1;
                    wid[r] = WIDW'($urandom);
                    idx[r] = RIW'($urandom);
                end
            end
            for (int b = 0; b < NB; b++) begin
                busy[b]  = ($urandom_range(5) == 0);
                bdata[b] = DW'($urandom);
            end
            eval();
            adv();
        end

        // Drain the last responses.
        v = '0;
        busy = '0;
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < NB; b++) bdata[b] = DW'($urandom);
            eval();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
